// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: the owner keeps the grant for up to its weight in accepted beats, then the search resumes at owner+1.
// Grant latency is 1 cycle. Optional feature macro ARB_LOCK_EN adds a lock input that holds the tenure past exhaustion.
module weighted_rr_arbiter #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  gnt_ready,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]          lock,
`endif
  output logic [N-1:0]          gnt,
  output logic                  gnt_valid,
  output logic [$clog2(N)-1:0]  gnt_id
);

  localparam int IDW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      owner_q, owner_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] count_q, count_d;

  logic [WEIGHT_W-1:0] w_raw, eff_w, count_inc;
  logic                owner_req, beat, exhaust, tenure_end;
  logic [IDW-1:0]      owner_nxt, search_start, winner;

  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] start);
    logic found;
    int   j;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && r[j]) begin
        found   = 1'b1;
        rr_pick = IDW'(j);
      end
    end
  endfunction

  always_comb begin
    w_raw     = weight[int'(owner_q)*WEIGHT_W +: WEIGHT_W];
    eff_w     = (w_raw == '0) ? WEIGHT_W'(1) : w_raw;
    owner_req = req[owner_q];
    beat      = gnt_valid && gnt_ready && owner_req;
    // ">=" so that a weight lowered mid-tenure still ends it on the next beat
    exhaust   = beat && (({1'b0, count_q} + (WEIGHT_W+1)'(1)) >= {1'b0, eff_w});
    owner_nxt = (owner_q == IDW'(N-1)) ? '0 : owner_q + 1'b1;
`ifdef ARB_LOCK_EN
    tenure_end = (state_q == GRANT) &&
                 (!owner_req || (!lock[owner_q] && (exhaust || (count_q >= eff_w))));
    count_inc  = (beat && (count_q < eff_w)) ? count_q + 1'b1 : count_q;
`else
    tenure_end = (state_q == GRANT) && (!owner_req || exhaust);
    count_inc  = beat ? count_q + 1'b1 : count_q;
`endif
    // Starting at owner+1 puts the owner last, so it only wins again as the sole requester.
    search_start = (state_q == GRANT) ? owner_nxt : ptr_q;
    winner       = rr_pick(req, search_start);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          owner_d = winner;
          count_d = '0;
        end
      end
      GRANT: begin
        if (tenure_end) begin
          ptr_d   = owner_nxt;
          count_d = '0;
          if (|req) begin
            owner_d = winner;
          end else begin
            state_d = IDLE;
            owner_d = '0;
          end
        end else begin
          count_d = count_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    gnt_valid = (state_q == GRANT);
    gnt_id    = '0;
    if (state_q == GRANT) begin
      gnt[owner_q] = 1'b1;
      gnt_id       = owner_q;
    end
  end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: directed grant sequences plus randomized traffic against a tenure-level model.
module tb_weighted_rr_arbiter;
  localparam int N  = 4;
  localparam int WW = 3;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [N-1:0]  req       = '0;
  logic [N*WW-1:0] weight  = '0;
  logic          gnt_ready = 1'b0;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [1:0]    gnt_id;

  int n_checks = 0;
  int n_err    = 0;

  // Model: current owner (-1 when idle), accepted beats this tenure, search pointer.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;

  logic [N-1:0] seq_rr [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] seq_w  [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100,
                                4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
  logic [N-1:0] seq_z  [4]  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

  always #5 clk = ~clk;

  weighted_rr_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .weight    (weight),
    .gnt_ready (gnt_ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at start, start+1, ... skipping 'skip'; 'skip' itself only as a last resort.
  function automatic int pick(input logic [N-1:0] r, input int start, input int skip);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if (j != skip && r[j]) return j;
    end
    if (skip >= 0 && r[skip]) return skip;
    return -1;
  endfunction

  task automatic model_step();
    logic [N*WW-1:0] sh;
    int w;
    bit done;
    if (m_owner < 0) begin
      m_owner = pick(req, m_ptr, -1);
      m_beats = 0;
    end else begin
      sh = weight >> (m_owner * WW);
      w  = int'(sh[WW-1:0]);
      if (w == 0) w = 1;
      done = 1'b0;
      if (!req[m_owner]) done = 1'b1;
      else if (gnt_ready) begin
        m_beats++;
        done = (m_beats >= w);
      end
      if (done) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = pick(req, m_ptr, m_owner);
        m_beats = 0;
      end
    end
  endtask

  // Compare process: advance the model on every edge and check the registered outputs just after.
  initial begin
    forever begin
      logic [N-1:0] e;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
      end else begin
        model_step();
      end
      #1;
      e = '0;
      if (m_owner >= 0) e[m_owner] = 1'b1;
      chk("model_gnt", gnt, e);
      chk("model_gnt_valid", gnt_valid, (m_owner >= 0));
      chk("model_gnt_id", gnt_id, (m_owner >= 0) ? m_owner : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered at posedge+2; leaves rst_n released at posedge+3, off both clock edges.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_gnt", gnt, 0);
    chk("reset_gnt_valid", gnt_valid, 0);
    chk("reset_gnt_id", gnt_id, 0);
    #1 rst_n = 1'b1;

    // Equal weights: plain rotation without idle cycles.
    weight = {4{3'd1}};
    req = 4'b1111;
    gnt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_equal_weights", gnt, seq_rr[i]);
    end

    // Weights {3,1,2,1} for requesters 0..3.
    do_reset();
    weight = {3'd1, 3'd2, 3'd1, 3'd3};
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rr_weighted", gnt, seq_w[i]);
    end

    // Zero weight behaves as one beat.
    do_reset();
    weight = '0;
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("zero_weight", gnt, seq_z[i]);
    end

    // Backpressure holds the grant; sole requester re-granted with count cleared.
    do_reset();
    weight = {3'd1, 3'd1, 3'd1, 3'd2};
    req = 4'b0001;
    gnt_ready = 1'b0;
    tick();
    chk("bp_first_grant", gnt, 4'b0001);
    gnt_ready = 1'b1; tick(); chk("bp_hold_1", gnt, 4'b0001);
    gnt_ready = 1'b0; tick(); chk("bp_hold_2", gnt, 4'b0001);
    gnt_ready = 1'b0; tick(); chk("bp_hold_3", gnt, 4'b0001);
    gnt_ready = 1'b1; tick(); chk("bp_regrant", gnt, 4'b0001);
    req = 4'b0011;
    tick(); chk("bp_count_cleared", gnt, 4'b0001);
    tick(); chk("bp_then_next", gnt, 4'b0010);

    // Owner drops request mid-tenure.
    do_reset();
    weight = {4{3'd3}};
    req = 4'b0100;
    tick(); chk("drop_grant2", gnt, 4'b0100);
    req = 4'b1111;
    tick(); chk("drop_hold2", gnt, 4'b0100);
    req = 4'b1011;
    tick(); chk("drop_next_is_3", gnt, 4'b1000);
    chk("drop_next_id", gnt_id, 3);
    req = 4'b0000;
    tick(); chk("drop_idle_gnt", gnt, 0);
    chk("drop_idle_valid", gnt_valid, 0);

    // Asynchronous reset mid-tenure, off the clock edge.
    do_reset();
    weight = {4{3'd3}};
    req = 4'b0001;
    tick();
    tick(); chk("arst_pre", gnt, 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_valid", gnt_valid, 0);
    chk("arst_id", gnt_id, 0);
    req = 4'b0110;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("arst_first_gnt", gnt, 4'b0010);
    chk("arst_first_id", gnt_id, 1);

    // Randomized traffic, weight changes mid-tenure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom;
        req = r[N-1:0];
      end
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom;
        weight = r[N*WW-1:0];
      end
      gnt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
